// File: rtl/jesd_pkg.sv
// Shared JESD204B TX definitions: sync-controller states, link-mux selects, default widths.
package jesd_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int ERR_CNT_W_DEF   = 8;
  localparam int LOW_CNT_W       = 5;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_MEAS      = 4'b0010,
    ST_REINIT    = 4'b0100,
    ST_WAIT_LMFC = 4'b1000
  } sync_state_e;

  typedef enum logic [1:0] {
    MUX_DATA = 2'd0,
    MUX_K    = 2'd1,
    MUX_ILA  = 2'd2
  } link_mux_sel_e;

  // A programmed threshold of zero would never match a post-increment count.
  function automatic logic [LOW_CNT_W-1:0] reinit_thr(input logic [LOW_CNT_W-1:0] frames);
    return (frames == '0) ? {{(LOW_CNT_W-1){1'b0}}, 1'b1} : frames;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchroniser for a single asynchronous bit; resets to 0, latency N clk.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/jesd_sync_ctrl.sv
// JESD204B TX SYNC~ controller: classifies SYNC~ low periods as glitch / error report / re-init
// and releases the re-init request on an LMFC boundary. Pin-to-state latency SYNC_STAGES+1 clk.
module jesd_sync_ctrl
  import jesd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_clk,
  input  logic                 lmfc_clk,
  input  logic                 i_sync_n,
  input  logic                 i_err_reporting,
  input  logic [4:0]           i_reinit_frames,
  input  logic                 i_err_cnt_clr,
  output logic                 o_sync_request_tx,
  output logic                 o_err_report,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [4:0]           o_low_frames
);

  logic sync_s;

  sync_bit #(
    .N(SYNC_STAGES)
  ) u_sync_bit (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (i_sync_n),
    .q    (sync_s)
  );

  sync_state_e          state_q, state_d;
  logic [4:0]           low_cnt_q, low_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 req_q, req_d;
  logic                 rep_q, rep_d;
  logic                 err_ev;
  logic [4:0]           thr;

  assign thr = reinit_thr(i_reinit_frames);

  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    err_ev    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!sync_s) begin
          if (i_err_reporting) begin
            state_d   = ST_MEAS;
            low_cnt_d = '0;
          end else begin
            state_d = ST_REINIT;
          end
        end
      end
      ST_MEAS: begin
        // A rising SYNC~ wins over a same-cycle frame boundary.
        if (sync_s) begin
          state_d = ST_IDLE;
          err_ev  = (low_cnt_q != '0);
        end else if (frame_clk) begin
          if (low_cnt_q != 5'd31) begin
            low_cnt_d = low_cnt_q + 5'd1;
          end
          // >= so a threshold lowered mid-measurement still fires on the next frame.
          if (low_cnt_d >= thr) begin
            state_d = ST_REINIT;
          end
        end
      end
      ST_REINIT: begin
        if (sync_s) begin
          state_d = ST_WAIT_LMFC;
        end
      end
      ST_WAIT_LMFC: begin
        if (!sync_s) begin
          state_d = ST_REINIT;
        end else if (lmfc_clk) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_REINIT;
    endcase

    if (i_err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (err_ev && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end

    req_d = (state_d == ST_REINIT) || (state_d == ST_WAIT_LMFC);
    rep_d = err_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REINIT;
      low_cnt_q <= '0;
      err_cnt_q <= '0;
      req_q     <= 1'b1;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
      err_cnt_q <= err_cnt_d;
      req_q     <= req_d;
      rep_q     <= rep_d;
    end
  end

  assign o_sync_request_tx = req_q;
  assign o_err_report      = rep_q;
  assign o_err_cnt         = err_cnt_q;
  assign o_low_frames      = low_cnt_q;

endmodule

// File: tb/tb_jesd_sync_ctrl.sv
// Directed bench for jesd_sync_ctrl: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_jesd_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clk;
  logic       lmfc_clk;
  logic       i_sync_n;
  logic       i_err_reporting;
  logic [4:0] i_reinit_frames;
  logic       i_err_cnt_clr;
  logic       o_sync_request_tx;
  logic       o_err_report;
  logic [7:0] o_err_cnt;
  logic [4:0] o_low_frames;

  int errors = 0;
  int checks = 0;

  jesd_sync_ctrl #(
    .SYNC_STAGES(2),
    .ERR_CNT_W  (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_clk        (frame_clk),
    .lmfc_clk         (lmfc_clk),
    .i_sync_n         (i_sync_n),
    .i_err_reporting  (i_err_reporting),
    .i_reinit_frames  (i_reinit_frames),
    .i_err_cnt_clr    (i_err_cnt_clr),
    .o_sync_request_tx(o_sync_request_tx),
    .o_err_report     (o_err_report),
    .o_err_cnt        (o_err_cnt),
    .o_low_frames     (o_low_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sync_n;
    logic frame;
    int   exp_req;
    int   exp_rep;
    int   exp_cnt;
    int   exp_low;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, then let one rising edge pass; outputs are read 2 ns after it.
  task automatic drive(input logic s, input logic f, input logic l, input logic c);
    i_sync_n      = s;
    frame_clk     = f;
    lmfc_clk      = l;
    i_err_cnt_clr = c;
    @(posedge clk);
    #2;
  endtask

  // One-frame SYNC~ pulse; the report appears after the last drive.
  task automatic pulse(input logic clr_on_report);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, clr_on_report);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 0, 0, 0, 1};
    tbl[4]  = '{1'b1, 1'b0, 0, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b1, 0, 0, 0, 2};
    tbl[6]  = '{1'b1, 1'b0, 0, 1, 1, 2};
    tbl[7]  = '{1'b1, 1'b0, 0, 0, 1, 2};
    tbl[8]  = '{1'b0, 1'b0, 0, 0, 1, 2};
    tbl[9]  = '{1'b1, 1'b0, 0, 0, 1, 2};
    tbl[10] = '{1'b1, 1'b0, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b1, 0, 0, 1, 0};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 1, 0};

    rst_n           = 1'b0;
    i_sync_n        = 1'b0;
    frame_clk       = 1'b0;
    lmfc_clk        = 1'b0;
    i_err_reporting = 1'b1;
    i_reinit_frames = 5'd6;
    i_err_cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", o_sync_request_tx, 1);
    chk("rst_rep", o_err_report, 0);
    chk("rst_cnt", o_err_cnt, 0);
    chk("rst_low", o_low_frames, 0);

    // Bring-up: SYNC~ low for 20 frames, request must hold through LMFC pulses.
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, (i % 4) == 3, (i % 16) == 15, 1'b0);
      chk("bringup_req_low", o_sync_request_tx, 1);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 4) == 3, 1'b0, 1'b0);
      chk("bringup_req_high", o_sync_request_tx, 1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("bringup_req_drop", o_sync_request_tx, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("bringup_req_idle", o_sync_request_tx, 0);

    // Two-frame error report followed by a sub-frame glitch with a same-cycle frame.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].sync_n, tbl[i].frame, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_req", i), o_sync_request_tx, tbl[i].exp_req);
      chk($sformatf("tbl%0d_rep", i), o_err_report, tbl[i].exp_rep);
      chk($sformatf("tbl%0d_cnt", i), o_err_cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_low", i), o_low_frames, tbl[i].exp_low);
    end

    // Six-frame low with threshold 6 becomes a re-init.
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("reinit6_low%0d", k), o_low_frames, k);
      chk($sformatf("reinit6_req%0d", k), o_sync_request_tx, (k == 6) ? 1 : 0);
      if (k < 6) repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i % 4) == 0, 1'b0, 1'b0);
      chk("reinit6_hold_req", o_sync_request_tx, 1);
      chk("reinit6_hold_low", o_low_frames, 6);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reinit6_wait_req", o_sync_request_tx, 1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("reinit6_drop", o_sync_request_tx, 0);
    chk("reinit6_no_rep", o_err_report, 0);
    chk("reinit6_cnt", o_err_cnt, 1);

    // Error reporting off: a one-clock low is a re-init after 3 clk.
    i_err_reporting = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("noerr_req_t1", o_sync_request_tx, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("noerr_req_t2", o_sync_request_tx, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("noerr_req_t3", o_sync_request_tx, 1);
    chk("noerr_no_rep", o_err_report, 0);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);

    // SYNC~ re-asserted in WAIT_LMFC together with an LMFC pulse.
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wait_lmfc_vs_sync", o_sync_request_tx, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("reinit_ignores_lmfc", o_sync_request_tx, 1);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wait_lmfc_req", o_sync_request_tx, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("wait_lmfc_drop", o_sync_request_tx, 0);
    i_err_reporting = 1'b1;

    // Counter clear, saturation and clear-vs-increment priority.
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("cnt_clear", o_err_cnt, 0);
    pulse(1'b0);
    chk("sat_first_rep", o_err_report, 1);
    chk("sat_first_cnt", o_err_cnt, 1);
    for (int i = 2; i <= 300; i++) begin
      pulse(1'b0);
      if (i == 100) chk("sat_cnt100", o_err_cnt, 100);
    end
    chk("sat_cnt255", o_err_cnt, 255);
    chk("sat_req", o_sync_request_tx, 0);
    pulse(1'b1);
    chk("clr_vs_rep_sat_rep", o_err_report, 1);
    chk("clr_vs_rep_sat_cnt", o_err_cnt, 0);
    pulse(1'b1);
    chk("clr_vs_rep_zero_cnt", o_err_cnt, 0);
    pulse(1'b0);
    chk("cnt_after_clr", o_err_cnt, 1);

    // Asynchronous reset mid-operation, then re-init requested with SYNC~ already high.
    rst_n = 1'b0;
    #1;
    chk("arst_req", o_sync_request_tx, 1);
    chk("arst_cnt", o_err_cnt, 0);
    chk("arst_low", o_low_frames, 0);
    chk("arst_rep", o_err_report, 0);
    rst_n = 1'b1;
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_req", o_sync_request_tx, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_drop", o_sync_request_tx, 0);

    // Threshold 0 behaves as 1: a single frame of low is a re-init.
    i_reinit_frames = 5'd0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("thr0_pre_req", o_sync_request_tx, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("thr0_req", o_sync_request_tx, 1);
    chk("thr0_low", o_low_frames, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
